// File: rtl/anim_pkg.sv
// Shared sprite-animation types and frame codes for the sequencer,
// the sprite ROM/palette mux and every player instance.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    AIR  = 2'd2
  } anim_state_t;

  localparam logic [2:0] FRAME_IDLE = 3'd0;
  localparam logic [2:0] FRAME_RUN1 = 3'd1;
  localparam logic [2:0] FRAME_JUMP = 3'd7;

  // Run frames cycle 1..last and wrap back to the first run frame.
  function automatic logic [2:0] next_run_frame(input logic [2:0] cur,
                                                input logic [2:0] last);
    return (cur >= last) ? FRAME_RUN1 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/vsync_edge.sv
// Registered rising-edge detector: one-cycle tick on each low-to-high
// transition of a level that is already synchronous to clk.
module vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic tick
);

  logic level_q;
  logic level_d;

  always_comb level_d = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_d;
  end

  assign tick = level & ~level_q;

endmodule

// File: rtl/run_anim_ctrl.sv
// Per-player sprite animation sequencer: selects idle/run/jump frame and
// facing direction, updating only on vsync rising edges.
module run_anim_ctrl
  import anim_pkg::*;
#(
  parameter int RUN_FRAMES = 3,
  parameter int HOLD_VSYNC = 6,
  parameter int MIN_AIR    = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vsync,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump_req,
  input  logic       on_ground,
  output logic [2:0] frame_sel,
  output logic       facing_left,
  output logic [1:0] anim_state,
  output logic       frame_tick
);

  localparam logic [5:0] HOLD_LAST = 6'(HOLD_VSYNC - 1);
  localparam logic [7:0] AIR_MIN   = 8'(MIN_AIR);
  localparam logic [2:0] RUN_LAST  = 3'(RUN_FRAMES);

  logic tick;
  logic dir_valid;

  anim_state_t state_q, state_d;
  logic [2:0]  frame_q, frame_d;
  logic        facing_q, facing_d;
  logic [5:0]  hold_q, hold_d;
  logic [7:0]  air_q, air_d;
  logic        frame_tick_q, frame_tick_d;

  vsync_edge u_vsync_edge (
    .clk   (Clk),
    .rst_n (Reset_n),
    .level (vsync),
    .tick  (tick)
  );

  assign dir_valid = move_left ^ move_right;

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    facing_d     = facing_q;
    hold_d       = hold_q;
    air_d        = air_q;
    frame_tick_d = tick;
    if (tick) begin
      if (dir_valid) facing_d = move_left;
      unique case (state_q)
        IDLE: begin
          if (jump_req) begin
            state_d = AIR;
            frame_d = FRAME_JUMP;
            air_d   = 8'd0;
          end else if (dir_valid) begin
            state_d = RUN;
            frame_d = FRAME_RUN1;
            hold_d  = 6'd0;
          end else begin
            frame_d = FRAME_IDLE;
          end
        end
        RUN: begin
          if (jump_req) begin
            state_d = AIR;
            frame_d = FRAME_JUMP;
            air_d   = 8'd0;
          end else if (!dir_valid) begin
            state_d = IDLE;
            frame_d = FRAME_IDLE;
            hold_d  = 6'd0;
          end else if (hold_q == HOLD_LAST) begin
            // Direction reversals land here too: the run cycle keeps going.
            hold_d  = 6'd0;
            frame_d = next_run_frame(frame_q, RUN_LAST);
          end else begin
            hold_d  = hold_q + 6'd1;
          end
        end
        AIR: begin
          frame_d = FRAME_JUMP;
          if (on_ground && (air_q == AIR_MIN)) begin
            if (dir_valid) begin
              state_d = RUN;
              frame_d = FRAME_RUN1;
              hold_d  = 6'd0;
            end else begin
              state_d = IDLE;
              frame_d = FRAME_IDLE;
            end
          end else if (air_q != AIR_MIN) begin
            air_d = air_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          frame_d = FRAME_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      frame_q      <= FRAME_IDLE;
      facing_q     <= 1'b0;
      hold_q       <= 6'd0;
      air_q        <= 8'd0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      facing_q     <= facing_d;
      hold_q       <= hold_d;
      air_q        <= air_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_sel   = frame_q;
  assign facing_left = facing_q;
  assign anim_state  = state_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_run_anim_ctrl.sv
// Directed bench for run_anim_ctrl with default parameters
// (RUN_FRAMES=3, HOLD_VSYNC=6, MIN_AIR=8).
module tb_run_anim_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       vsync = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       jump_req = 1'b0;
  logic       on_ground = 1'b0;
  logic [2:0] frame_sel;
  logic       facing_left;
  logic [1:0] anim_state;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;

  run_anim_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vsync       (vsync),
    .move_left   (move_left),
    .move_right  (move_right),
    .jump_req    (jump_req),
    .on_ground   (on_ground),
    .frame_sel   (frame_sel),
    .facing_left (facing_left),
    .anim_state  (anim_state),
    .frame_tick  (frame_tick)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (frame_tick === 1'b1) tick_count++;

  // One vsync pulse; returns 1 time unit after the edge that sampled it high.
  task automatic do_tick();
    @(negedge Clk); vsync = 1'b0;
    @(negedge Clk); vsync = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (frame_sel !== 3'd0) begin errors++; $display("FAIL reset_frame got %0d exp 0", frame_sel); end
    checks++; if (anim_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", anim_state); end
    checks++; if (facing_left !== 1'b0) begin errors++; $display("FAIL reset_facing got %0b exp 0", facing_left); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b exp 0", frame_tick); end
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic test_idle();
    int base;
    base = tick_count;
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL idle_tick%0d got %0b exp 1", k, frame_tick); end
      checks++; if (frame_sel !== 3'd0) begin errors++; $display("FAIL idle_frame%0d got %0d exp 0", k, frame_sel); end
      checks++; if (anim_state !== 2'd0) begin errors++; $display("FAIL idle_state%0d got %0d exp 0", k, anim_state); end
    end
    @(posedge Clk); #1;
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL idle_tick_pulse got %0b exp 0", frame_tick); end
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (tick_count - base !== 3) begin errors++; $display("FAIL idle_tick_count got %0d exp 3", tick_count - base); end
    checks++; if (facing_left !== 1'b0) begin errors++; $display("FAIL idle_facing got %0b exp 0", facing_left); end
  endtask

  task automatic test_run_cycle();
    logic [2:0] exp;
    move_right = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      do_tick();
      if (k == 1 || k == 6 || k == 7 || k == 12 || k == 13 || k == 18 || k == 19) begin
        case (k)
          1, 6:   exp = 3'd1;
          7, 12:  exp = 3'd2;
          13, 18: exp = 3'd3;
          default: exp = 3'd1;
        endcase
        checks++; if (frame_sel !== exp) begin errors++; $display("FAIL run_frame_t%0d got %0d exp %0d", k, frame_sel, exp); end
      end
    end
    checks++; if (anim_state !== 2'd1) begin errors++; $display("FAIL run_state got %0d exp 1", anim_state); end
    checks++; if (facing_left !== 1'b0) begin errors++; $display("FAIL run_facing got %0b exp 0", facing_left); end
  endtask

  // Continues from tick 19 (frame 1, hold 0).
  task automatic test_reverse();
    do_tick();
    move_right = 1'b0;
    move_left  = 1'b1;
    do_tick();
    checks++; if (facing_left !== 1'b1) begin errors++; $display("FAIL rev_facing got %0b exp 1", facing_left); end
    checks++; if (frame_sel !== 3'd1) begin errors++; $display("FAIL rev_frame got %0d exp 1", frame_sel); end
    repeat (3) do_tick();
    checks++; if (frame_sel !== 3'd1) begin errors++; $display("FAIL rev_frame_t24 got %0d exp 1", frame_sel); end
    do_tick();
    checks++; if (frame_sel !== 3'd2) begin errors++; $display("FAIL rev_frame_t25 got %0d exp 2", frame_sel); end
    checks++; if (anim_state !== 2'd1) begin errors++; $display("FAIL rev_state got %0d exp 1", anim_state); end
  endtask

  task automatic test_jump_priority();
    jump_req  = 1'b1;
    move_left = 1'b0;
    do_tick();
    checks++; if (anim_state !== 2'd2) begin errors++; $display("FAIL jump_state got %0d exp 2", anim_state); end
    checks++; if (frame_sel !== 3'd7) begin errors++; $display("FAIL jump_frame got %0d exp 7", frame_sel); end
    checks++; if (facing_left !== 1'b1) begin errors++; $display("FAIL jump_facing got %0b exp 1", facing_left); end
  endtask

  // Already in AIR with air_cnt 0; jump_req stays high to show it is ignored.
  task automatic test_land_idle();
    on_ground = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      checks++; if (anim_state !== 2'd2) begin errors++; $display("FAIL air_state_t%0d got %0d exp 2", k, anim_state); end
      checks++; if (frame_sel !== 3'd7) begin errors++; $display("FAIL air_frame_t%0d got %0d exp 7", k, frame_sel); end
    end
    do_tick();
    checks++; if (anim_state !== 2'd0) begin errors++; $display("FAIL land_idle_state got %0d exp 0", anim_state); end
    checks++; if (frame_sel !== 3'd0) begin errors++; $display("FAIL land_idle_frame got %0d exp 0", frame_sel); end
    jump_req = 1'b0;
  endtask

  task automatic test_land_run();
    jump_req   = 1'b1;
    move_right = 1'b1;
    do_tick();
    checks++; if (anim_state !== 2'd2) begin errors++; $display("FAIL jump2_state got %0d exp 2", anim_state); end
    checks++; if (facing_left !== 1'b0) begin errors++; $display("FAIL jump2_facing got %0b exp 0", facing_left); end
    jump_req   = 1'b0;
    move_right = 1'b0;
    move_left  = 1'b1;
    do_tick();
    checks++; if (facing_left !== 1'b1) begin errors++; $display("FAIL air_facing got %0b exp 1", facing_left); end
    checks++; if (anim_state !== 2'd2) begin errors++; $display("FAIL air_facing_state got %0d exp 2", anim_state); end
    repeat (7) do_tick();
    checks++; if (anim_state !== 2'd2) begin errors++; $display("FAIL air_t8_state got %0d exp 2", anim_state); end
    do_tick();
    checks++; if (anim_state !== 2'd1) begin errors++; $display("FAIL land_run_state got %0d exp 1", anim_state); end
    checks++; if (frame_sel !== 3'd1) begin errors++; $display("FAIL land_run_frame got %0d exp 1", frame_sel); end
    on_ground = 1'b0;
  endtask

  task automatic test_async_reset();
    int base;
    repeat (12) do_tick();
    checks++; if (frame_sel !== 3'd3) begin errors++; $display("FAIL pre_reset_frame got %0d exp 3", frame_sel); end
    #2;
    Reset_n = 1'b0;
    vsync   = 1'b1;
    move_left = 1'b0;
    #1;
    checks++; if (frame_sel !== 3'd0) begin errors++; $display("FAIL async_frame got %0d exp 0", frame_sel); end
    checks++; if (anim_state !== 2'd0) begin errors++; $display("FAIL async_state got %0d exp 0", anim_state); end
    checks++; if (facing_left !== 1'b0) begin errors++; $display("FAIL async_facing got %0b exp 0", facing_left); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL async_tick got %0b exp 0", frame_tick); end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    base = tick_count;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL release_tick got %0b exp 1", frame_tick); end
    repeat (6) @(posedge Clk);
    #1;
    checks++; if (tick_count - base !== 1) begin errors++; $display("FAIL held_vsync_ticks got %0d exp 1", tick_count - base); end
    checks++; if (anim_state !== 2'd0) begin errors++; $display("FAIL release_state got %0d exp 0", anim_state); end
    vsync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_run_cycle();
    test_reverse();
    test_jump_priority();
    test_land_idle();
    test_land_run();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
